bgr_trim_seq: RTL and testbench
===============================

// Module: bgr_trim_seq
// PURPOSE
//   Digital start-up and trim sequencer for the bandgap macro. Pulses porst (kick device pulling
//   vc low) to force the core out of its zero-current state, waits for settling, then runs a
//   successive-approximation search on the resistor-ladder trim code against an external
//   comparator. Sits in the always-on digital domain beside bgr_top; supervises vbg and re-kicks on dropout.
// PARAMETERS
//   TRIM_W     4    trim code width; SAR takes TRIM_W steps
//   PULSE_CYC  16   porst high time in clk cycles (>=1)
//   SETTLE_CYC 256  wait after porst falls before checking vbg_ok (>=1)
//   STEP_CYC   32   wait per SAR step before sampling cmp_hi (>=2)
//   MAX_RETRY  3    kicks allowed after the first before declaring fault
//   DROP_CYC   4    consecutive vbg_ok=0 cycles in READY that count as dropout
//   CNT_W      9    timer width; must hold max(PULSE_CYC,SETTLE_CYC,STEP_CYC)
// PORTS
//   clk          in   1       sequencer clock
//   rst          in   1       synchronous reset, active high
//   en           in   1       1 = run sequence; 0 = return to IDLE next cycle
//   vbg_ok       in   1       async, analog UV detector: vbg above minimum
//   cmp_hi       in   1       async, trim comparator: 1 = vbg above target
//   trim_ovr_en  in   1       1 = bypass SAR, use trim_ovr
//   trim_ovr     in   TRIM_W  override trim code
//   porst        out  1       start-up kick to gate of pull-down on vc
//   trim         out  TRIM_W  ladder tap select; larger code = higher vbg
//   ready        out  1       vbg trimmed and valid
//   fault        out  1       start-up failed after MAX_RETRY retries (sticky until rst or en=0)
//   busy         out  1       state not IDLE/READY/FAULT
// BEHAVIOUR
//   Reset: state=IDLE, porst=0, trim=2^(TRIM_W-1), ready=0, fault=0, busy=0, timer=0, retry=0.
//   vbg_ok, cmp_hi pass 2-flop synchronisers; all decisions use synchronised values (2-cycle lag).
//   All outputs registered. en=0 in any state -> IDLE next cycle, outputs to reset values.
//   IDLE:   en=1 -> KICK; retry=0.
//   KICK:   porst=1 for exactly PULSE_CYC cycles, then SETTLE.
//   SETTLE: porst=0; after SETTLE_CYC cycles: vbg_ok=1 -> (trim_ovr_en ? READY : SAR);
//           vbg_ok=0 -> retry==MAX_RETRY ? FAULT : (retry++, KICK).
//   SAR:    bit b from TRIM_W-1 down to 0: set trim[b]=1 (lower bits 0), wait STEP_CYC cycles,
//           sample cmp_hi on last wait cycle; cmp_hi=1 -> clear trim[b], else keep. After b=0 -> READY.
//           Initial code 2^(TRIM_W-1); result is largest code with cmp_hi=0 (all-1 / all-0 at rails).
//   READY:  ready=1. trim_ovr_en=1 -> trim=trim_ovr live (registered, 1-cycle latency);
//           0 -> holds SAR result. DROP_CYC consecutive vbg_ok=0 -> ready=0, retry=0, KICK.
//           Shorter vbg_ok glitches ignored; count clears on any vbg_ok=1.
//   FAULT:  porst=0, ready=0, fault=1, trim holds last value; exit only via rst or en=0.
//   trim_ovr_en sampled at SETTLE exit; toggling it during SAR has no effect until READY.
//   trim_ovr_en=1 during KICK/SETTLE: trim=trim_ovr immediately (kick at intended code).
//   rst mid-SAR or mid-KICK: porst drops and trim returns to mid-code next cycle.
//   Timer counts down; no wrap: loads N-1 on state entry, advances at 0.
// TESTING
//   1 en=1, vbg_ok=1, cmp_hi=1 iff trim>=11 (TRIM_W=4) -> porst high 16 cycles, ready after
//     16+256+4*32 cycles (+sync lag), trim=10.
//   2 vbg_ok held 0 -> exactly 4 porst pulses (1+MAX_RETRY), then fault=1, ready=0, porst=0.
//   3 READY, vbg_ok low 3 cycles then high -> ready stays 1; low 4 cycles -> ready=0, new porst pulse.
//   4 trim_ovr_en=1, trim_ovr=5 -> no SAR steps, ready after 16+256 cycles, trim=5; change
//     trim_ovr to 9 -> trim=9 one cycle later.
//   5 cmp_hi stuck 1 -> trim=0; stuck 0 -> trim=15; both reach ready.
//   6 rst or en=0 asserted mid-SAR (step 2) -> next cycle IDLE, trim=8, porst=0, busy=0;
//     re-enable restarts from KICK.

Source files
------------

// File: rtl/bgr_trim_seq_if.sv
// Control and status bundle between the bandgap trim sequencer and its
// surroundings: enable, analog detector inputs, trim override, and the
// kick/trim/status outputs.
interface bgr_trim_seq_if #(
   parameter int TRIM_W = 4
);
   logic              en;
   logic              vbg_ok;
   logic              cmp_hi;
   logic              trim_ovr_en;
   logic [TRIM_W-1:0] trim_ovr;
   logic              porst;
   logic [TRIM_W-1:0] trim;
   logic              ready;
   logic              fault;
   logic              busy;

   modport master (
      output en, vbg_ok, cmp_hi, trim_ovr_en, trim_ovr,
      input  porst, trim, ready, fault, busy
   );

   modport slave (
      input  en, vbg_ok, cmp_hi, trim_ovr_en, trim_ovr,
      output porst, trim, ready, fault, busy
   );
endinterface

// File: rtl/bgr_trim_seq.sv
// Bandgap start-up and trim sequencer. Kicks the core out of its zero-current
// state, waits for it to settle, binary-searches the ladder trim code against
// the external comparator, then supervises vbg and re-kicks on dropout.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | disabled; outputs at reset values, trim at mid-code
// KICK   | porst high for PULSE_CYC cycles
// SETTLE | porst low, wait SETTLE_CYC cycles, then judge vbg_ok
// SAR    | one trim bit per STEP_CYC window, MSB first
// READY  | trimmed and valid; DROP_CYC consecutive vbg_ok=0 -> re-kick
// FAULT  | start-up failed after all retries; sticky until rst / en=0
module bgr_trim_seq #(
   parameter int TRIM_W     = 4,
   parameter int PULSE_CYC  = 16,
   parameter int SETTLE_CYC = 256,
   parameter int STEP_CYC   = 32,
   parameter int MAX_RETRY  = 3,
   parameter int DROP_CYC   = 4,
   parameter int CNT_W      = 9
) (
   input logic           clk,
   input logic           rst,
   bgr_trim_seq_if.slave bus
);

   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int BW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

   localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]  STEP_LD   = CNT_W'(STEP_CYC - 1);
   localparam logic [CNT_W-1:0]  DROP_LD   = CNT_W'(DROP_CYC - 1);
   localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
   localparam logic [BW-1:0]     MSB_IDX   = BW'(TRIM_W - 1);
   localparam logic [TRIM_W-1:0] MID_CODE  = {1'b1, {(TRIM_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_KICK,
      S_SETTLE,
      S_SAR,
      S_READY,
      S_FAULT
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  timer;
   logic [RW-1:0]     retry;
   logic [BW-1:0]     bit_idx;
   logic              porst_q;
   logic [TRIM_W-1:0] trim_q;
   logic              ready_q;
   logic              fault_q;
   logic              busy_q;

   logic              vbg_s1, vbg_s2;
   logic              cmp_s1, cmp_s2;
   logic              tc;
   logic [TRIM_W-1:0] sar_next;

   assign tc = (timer == '0);

   // Two-flop synchronisers for the asynchronous analog detector outputs.
   always_ff @(posedge clk) begin
      vbg_s1 <= bus.vbg_ok;
      vbg_s2 <= vbg_s1;
      cmp_s1 <= bus.cmp_hi;
      cmp_s2 <= cmp_s1;
   end

   // Trim code after the current SAR step: drop the trial bit if vbg is too
   // high, then raise the next lower bit as the following trial.
   always_comb begin
      sar_next = trim_q;
      if (cmp_s2) begin
         sar_next[bit_idx] = 1'b0;
      end
      if (bit_idx != '0) begin
         sar_next[bit_idx - 1'b1] = 1'b1;
      end
   end

   // Sequencer FSM with registered outputs; en=0 aborts like reset.
   always_ff @(posedge clk) begin
      if (rst || !bus.en) begin
         state   <= S_IDLE;
         timer   <= '0;
         retry   <= '0;
         bit_idx <= MSB_IDX;
         porst_q <= 1'b0;
         trim_q  <= MID_CODE;
         ready_q <= 1'b0;
         fault_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state   <= S_KICK;
               retry   <= '0;
               timer   <= PULSE_LD;
               porst_q <= 1'b1;
               busy_q  <= 1'b1;
               if (bus.trim_ovr_en) trim_q <= bus.trim_ovr;
            end

            S_KICK: begin
               if (bus.trim_ovr_en) trim_q <= bus.trim_ovr;
               if (tc) begin
                  state   <= S_SETTLE;
                  porst_q <= 1'b0;
                  timer   <= SETTLE_LD;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            S_SETTLE: begin
               if (!tc) begin
                  timer <= timer - 1'b1;
                  if (bus.trim_ovr_en) trim_q <= bus.trim_ovr;
               end else if (vbg_s2) begin
                  // The override choice is latched here; SAR ignores it later.
                  if (bus.trim_ovr_en) begin
                     state   <= S_READY;
                     trim_q  <= bus.trim_ovr;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     timer   <= DROP_LD;
                  end else begin
                     state   <= S_SAR;
                     trim_q  <= MID_CODE;
                     bit_idx <= MSB_IDX;
                     timer   <= STEP_LD;
                  end
               end else if (retry == RETRY_MAX) begin
                  state   <= S_FAULT;
                  fault_q <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state   <= S_KICK;
                  retry   <= retry + 1'b1;
                  porst_q <= 1'b1;
                  timer   <= PULSE_LD;
                  if (bus.trim_ovr_en) trim_q <= bus.trim_ovr;
               end
            end

            S_SAR: begin
               if (tc) begin
                  trim_q <= sar_next;
                  if (bit_idx == '0) begin
                     state   <= S_READY;
                     ready_q <= 1'b1;
                     busy_q  <= 1'b0;
                     timer   <= DROP_LD;
                  end else begin
                     bit_idx <= bit_idx - 1'b1;
                     timer   <= STEP_LD;
                  end
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            S_READY: begin
               if (bus.trim_ovr_en) trim_q <= bus.trim_ovr;
               // Timer doubles as the dropout filter: any vbg_ok=1 reloads it.
               if (vbg_s2) begin
                  timer <= DROP_LD;
               end else if (tc) begin
                  state   <= S_KICK;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  porst_q <= 1'b1;
                  retry   <= '0;
                  timer   <= PULSE_LD;
               end else begin
                  timer <= timer - 1'b1;
               end
            end

            S_FAULT: begin
               porst_q <= 1'b0;
               ready_q <= 1'b0;
               fault_q <= 1'b1;
               busy_q  <= 1'b0;
            end

            default: begin
               state   <= S_IDLE;
               timer   <= '0;
               retry   <= '0;
               porst_q <= 1'b0;
               trim_q  <= MID_CODE;
               ready_q <= 1'b0;
               fault_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.porst = porst_q;
   assign bus.trim  = trim_q;
   assign bus.ready = ready_q;
   assign bus.fault = fault_q;
   assign bus.busy  = busy_q;

endmodule

// File: tb/tb_bgr_trim_seq.sv
// Bench for the bandgap trim sequencer: a timeline model of the start-up
// sequence predicts every output each cycle, and directed scenarios add
// hand-computed latency / code / count checks.
module tb_bgr_trim_seq;
   localparam int TRIM_W     = 4;
   localparam int PULSE_CYC  = 16;
   localparam int SETTLE_CYC = 256;
   localparam int STEP_CYC   = 32;
   localparam int MAX_RETRY  = 3;
   localparam int DROP_CYC   = 4;
   localparam int CNT_W      = 9;

   logic clk = 1'b0;
   logic rst;

   bgr_trim_seq_if #(.TRIM_W(TRIM_W)) bus ();

   bgr_trim_seq #(
      .TRIM_W(TRIM_W), .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC),
      .STEP_CYC(STEP_CYC), .MAX_RETRY(MAX_RETRY), .DROP_CYC(DROP_CYC),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit       m_porst, m_ready, m_fault, m_busy;
   int       m_trim;
   bit [1:0] vh, ch;
   bit       vu, cu, oe;
   int       ov;

   task automatic m_idle();
      m_porst = 1'b0; m_ready = 1'b0; m_fault = 1'b0; m_busy = 1'b0;
      m_trim  = 1 << (TRIM_W - 1);
   endtask

   // One clock edge: detector values seen by decisions are two edges old.
   task automatic m_tick(output bit ab);
      @(posedge clk);
      vu = vh[1];
      cu = ch[1];
      vh = {vh[0], bus.vbg_ok};
      ch = {ch[0], bus.cmp_hi};
      oe = bus.trim_ovr_en;
      ov = int'(bus.trim_ovr);
      ab = rst || !bus.en;
   endtask

   // Whole enabled sequence; returns on the edge that aborts it.
   task automatic m_run();
      bit ab;
      int retry;
      int code;
      int dc;
      retry = 0;
      m_porst = 1'b1; m_busy = 1'b1; m_ready = 1'b0;
      if (oe) m_trim = ov;
      forever begin
         for (int i = 1; i < PULSE_CYC; i++) begin
            m_tick(ab); if (ab) return;
            if (oe) m_trim = ov;
         end
         m_tick(ab); if (ab) return;
         m_porst = 1'b0;
         if (oe) m_trim = ov;
         for (int i = 1; i < SETTLE_CYC; i++) begin
            m_tick(ab); if (ab) return;
            if (oe) m_trim = ov;
         end
         m_tick(ab); if (ab) return;
         if (!vu) begin
            if (retry == MAX_RETRY) begin
               m_fault = 1'b1; m_busy = 1'b0;
               forever begin
                  m_tick(ab); if (ab) return;
               end
            end
            retry++;
            m_porst = 1'b1;
            if (oe) m_trim = ov;
            continue;
         end
         if (oe) begin
            m_trim = ov;
         end else begin
            code = 0;
            for (int b = TRIM_W - 1; b >= 0; b--) begin
               m_trim = code | (1 << b);
               for (int i = 1; i < STEP_CYC; i++) begin
                  m_tick(ab); if (ab) return;
               end
               m_tick(ab); if (ab) return;
               if (!cu) code = code | (1 << b);
            end
            m_trim = code;
         end
         m_ready = 1'b1; m_busy = 1'b0;
         dc = 0;
         while (1) begin
            m_tick(ab); if (ab) return;
            if (oe) m_trim = ov;
            dc = vu ? 0 : dc + 1;
            if (dc == DROP_CYC) break;
         end
         m_ready = 1'b0; m_busy = 1'b1; m_porst = 1'b1;
         retry = 0;
      end
   endtask

   initial begin : model
      bit ab;
      vh = '0; ch = '0;
      oe = 1'b0; ov = 0;
      m_idle();
      forever begin
         m_tick(ab);
         if (ab) begin
            m_idle();
         end else begin
            m_run();
            m_idle();
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin : compare
      forever begin
         @(negedge clk);
         if (chk_on) begin
            chk("cyc_porst", int'(bus.porst), int'(m_porst));
            chk("cyc_trim",  int'(bus.trim),  m_trim);
            chk("cyc_ready", int'(bus.ready), int'(m_ready));
            chk("cyc_fault", int'(bus.fault), int'(m_fault));
            chk("cyc_busy",  int'(bus.busy),  int'(m_busy));
         end
      end
   end

   // ---------------- comparator environment ----------------
   int cmp_mode = 0;   // 0: cmp_hi = trim >= thr, 1: stuck 1, 2: stuck 0
   int thr      = 11;

   initial begin : comparator
      forever begin
         @(negedge clk);
         case (cmp_mode)
            0:       bus.cmp_hi = (int'(bus.trim) >= thr);
            1:       bus.cmp_hi = 1'b1;
            default: bus.cmp_hi = 1'b0;
         endcase
      end
   end

   // ---------------- directed stimulus ----------------
   int cyc;
   int cnt;
   bit prev;

   task automatic restart();
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      bus.en = 1'b1;
   endtask

   task automatic wait_ready(input int limit, output int n);
      n = 0;
      while (!bus.ready && n < limit) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin : stim
      rst = 1'b1;
      bus.en = 1'b0;
      bus.vbg_ok = 1'b1;
      bus.cmp_hi = 1'b0;
      bus.trim_ovr_en = 1'b0;
      bus.trim_ovr = '0;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      chk("rst_trim",  int'(bus.trim),  8);
      chk("rst_porst", int'(bus.porst), 0);
      chk("rst_ready", int'(bus.ready), 0);
      chk("rst_busy",  int'(bus.busy),  0);
      chk("rst_fault", int'(bus.fault), 0);
      rst = 1'b0;
      @(negedge clk);

      // Normal start-up with SAR against a threshold of 11.
      bus.en = 1'b1;
      cyc = 0; cnt = 0;
      while (!bus.ready && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         if (bus.porst) cnt++;
      end
      chk("t1_ready_lat", cyc, 401);
      chk("t1_porst_len", cnt, 16);
      chk("t1_trim", int'(bus.trim), 10);

      // Three-cycle dropout is filtered.
      bus.vbg_ok = 1'b0;
      repeat (3) @(negedge clk);
      bus.vbg_ok = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.ready) cnt++;
      end
      chk("t3_glitch_ready_low", cnt, 0);

      // Four-cycle dropout re-kicks.
      bus.vbg_ok = 1'b0;
      repeat (4) @(negedge clk);
      bus.vbg_ok = 1'b1;
      cyc = 0;
      while (!bus.porst && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("t3_drop_rekick", int'(bus.porst), 1);
      chk("t3_drop_ready", int'(bus.ready), 0);
      wait_ready(1000, cyc);
      chk("t3_retrim", int'(bus.trim), 10);

      // Comparator stuck high and stuck low: trim pinned to the rails.
      cmp_mode = 1;
      restart();
      wait_ready(1000, cyc);
      chk("t5_stuck_hi_ready", int'(bus.ready), 1);
      chk("t5_stuck_hi_trim", int'(bus.trim), 0);
      cmp_mode = 2;
      restart();
      wait_ready(1000, cyc);
      chk("t5_stuck_lo_ready", int'(bus.ready), 1);
      chk("t5_stuck_lo_trim", int'(bus.trim), 15);

      // Override: no SAR, code applied during the kick already.
      cmp_mode = 0;
      bus.trim_ovr_en = 1'b1;
      bus.trim_ovr = 4'd5;
      restart();
      @(negedge clk);
      chk("t4_kick_trim", int'(bus.trim), 5);
      cyc = 1;
      wait_ready(1000, cnt);
      cyc = cyc + cnt;
      chk("t4_ready_lat", cyc, 273);
      chk("t4_trim", int'(bus.trim), 5);
      bus.trim_ovr = 4'd9;
      @(negedge clk);
      chk("t4_live_trim", int'(bus.trim), 9);
      bus.trim_ovr_en = 1'b0;

      // vbg never comes up: four kicks then fault.
      bus.en = 1'b0;
      bus.vbg_ok = 1'b0;
      repeat (4) @(negedge clk);
      bus.en = 1'b1;
      cyc = 0; cnt = 0; prev = 1'b0;
      while (!bus.fault && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (bus.porst && !prev) cnt++;
         prev = bus.porst;
      end
      chk("t2_pulses", cnt, 4);
      chk("t2_fault_lat", cyc, 1089);
      chk("t2_fault", int'(bus.fault), 1);
      chk("t2_ready", int'(bus.ready), 0);
      chk("t2_porst", int'(bus.porst), 0);
      repeat (5) @(negedge clk);
      chk("t2_fault_sticky", int'(bus.fault), 1);
      bus.en = 1'b0;
      @(negedge clk);
      chk("t2_fault_clear", int'(bus.fault), 0);

      // Abort in the middle of SAR step 2, first by rst then by en=0.
      bus.vbg_ok = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         bus.en = 1'b1;
         repeat (314) @(negedge clk);
         chk("t6_mid_busy", int'(bus.busy), 1);
         chk("t6_mid_trim", int'(bus.trim), 12);
         if (k == 0) rst = 1'b1; else bus.en = 1'b0;
         @(negedge clk);
         chk("t6_abort_trim",  int'(bus.trim),  8);
         chk("t6_abort_porst", int'(bus.porst), 0);
         chk("t6_abort_busy",  int'(bus.busy),  0);
         rst = 1'b0;
         bus.en = 1'b1;
         @(negedge clk);
         chk("t6_restart_porst", int'(bus.porst), 1);
         wait_ready(1000, cyc);
         chk("t6_restart_trim", int'(bus.trim), 10);
         bus.en = 1'b0;
         repeat (3) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
